branch_predictor: RTL and testbench

Dynamic 2-bit saturating branch predictor with a direct-mapped branch target buffer (BTB) for the 5-stage pipelined core. It replaces static not-taken fetch.
- Fetch side: predicts the next PC for the instruction being fetched.
- Decode side: checks the prediction against the beq resolution (eq computed in decode), produces flush/redirect on a mispredict, and trains the table.
- Also keeps branch and mispredict statistics counters.

---
 rtl/bp_pkg.sv | 20 ++
 rtl/sat_counter2.sv | 8 +
 rtl/branch_predictor.sv | 123 ++++++++++++
 tb/tb_branch_predictor.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared types for the branch predictor: counter encodings, BTB entry layout
// and the 2-bit saturating counter next-state function.
package bp_pkg;
  localparam int BP_PC_W = 32;

  typedef enum logic [1:0] {SNT = 2'b00, WNT = 2'b01, WT = 2'b10, ST = 2'b11} ctr_e;

  // Tag is held at full PC width; only the low TAG_BITS are ever non-zero.
  typedef struct packed {
    logic               valid;
    logic [BP_PC_W-1:0] tag;
    logic [BP_PC_W-1:0] target;
    logic [1:0]         ctr;
  } btb_entry_t;

  function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
    if (taken) return (ctr == ST)  ? ST  : ctr + 2'd1;
    else       return (ctr == SNT) ? SNT : ctr - 2'd1;
  endfunction
endpackage

// File: rtl/sat_counter2.sv
// 2-bit saturating counter next-state: +1 on taken, -1 on not taken, clamped.
module sat_counter2 import bp_pkg::*; (
  input  logic [1:0] ctr_i,
  input  logic       taken_i,
  output logic [1:0] ctr_o
);
  assign ctr_o = ctr_next(ctr_i, taken_i);
endmodule

// File: rtl/branch_predictor.sv
// Bimodal predictor with direct-mapped BTB: predicts in fetch, resolves beq in
// decode, flushes one slot on mispredict, trains the table, keeps statistics.
module branch_predictor import bp_pkg::*; #(
  parameter int INDEX_BITS = 4,
  parameter int TAG_BITS   = 8,
  parameter int PC_W       = BP_PC_W,
  parameter int CNT_W      = 16
)(
  input  logic             clk,
  input  logic             rstN,
  input  logic [PC_W-1:0]  fetchPc,
  input  logic             stall,
  input  logic             decIsBranch,
  input  logic             decEq,
  input  logic [PC_W-1:0]  decTarget,
  output logic [PC_W-1:0]  nextPc,
  output logic             predTaken,
  output logic             flush,
  output logic [CNT_W-1:0] branchCnt,
  output logic [CNT_W-1:0] mispredCnt
);
  localparam int ENTRIES = 1 << INDEX_BITS;

  btb_entry_t             btb_q [ENTRIES];
  logic                   s_valid_q, s_pred_q;
  logic [PC_W-1:0]        s_pc_q;
  logic [CNT_W-1:0]       br_cnt_q, br_cnt_d, mp_cnt_q, mp_cnt_d;

  logic [INDEX_BITS-1:0]  f_idx, s_idx;
  logic [BP_PC_W-1:0]     f_tag, s_tag;
  logic                   f_hit, s_hit, resolve, mispred;
  logic [PC_W-1:0]        pred_tgt, redirect;
  logic [1:0]             ctr_upd;

  // Fetch-side lookup
  assign f_idx     = fetchPc[INDEX_BITS+1:2];
  assign f_tag     = BP_PC_W'(fetchPc[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2]);
  assign f_hit     = btb_q[f_idx].valid && (btb_q[f_idx].tag == f_tag);
  assign predTaken = f_hit && btb_q[f_idx].ctr[1];
  assign pred_tgt  = predTaken ? PC_W'(btb_q[f_idx].target) : fetchPc + PC_W'(4);

  // Decode-side view of the same table, indexed by the shadowed fetch PC
  assign s_idx   = s_pc_q[INDEX_BITS+1:2];
  assign s_tag   = BP_PC_W'(s_pc_q[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2]);
  assign s_hit   = btb_q[s_idx].valid && (btb_q[s_idx].tag == s_tag);
  assign resolve = s_valid_q && !stall;

  always_comb begin
    mispred  = 1'b0;
    redirect = s_pc_q + PC_W'(4);
    if (resolve) begin
      if (decIsBranch) begin
        mispred = (s_pred_q != decEq);
        if (decEq) redirect = decTarget;
      end else begin
        mispred = s_pred_q;  // tag alias predicted a non-branch taken
      end
    end
  end

  assign flush  = mispred;
  assign nextPc = mispred ? redirect : pred_tgt;

  sat_counter2 u_ctr (
    .ctr_i   (btb_q[s_idx].ctr),
    .taken_i (decEq),
    .ctr_o   (ctr_upd)
  );

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      for (int i = 0; i < ENTRIES; i++)
        btb_q[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: WNT};
    end else if (resolve) begin
      if (decIsBranch) begin
        if (s_hit) begin
          btb_q[s_idx].ctr    <= ctr_upd;
          btb_q[s_idx].target <= BP_PC_W'(decTarget);
        end else begin
          btb_q[s_idx] <= '{valid: 1'b1, tag: s_tag, target: BP_PC_W'(decTarget),
                            ctr: (decEq ? WT : WNT)};
        end
      end else if (s_pred_q) begin
        btb_q[s_idx].valid <= 1'b0;
      end
    end
  end

  // IF/ID shadow: tracks what fetch predicted for the instruction now in decode
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      s_valid_q <= 1'b0;
      s_pred_q  <= 1'b0;
      s_pc_q    <= '0;
    end else if (flush) begin
      s_valid_q <= 1'b0;
    end else if (!stall) begin
      s_valid_q <= 1'b1;
      s_pred_q  <= predTaken;
      s_pc_q    <= fetchPc;
    end
  end

  always_comb begin
    br_cnt_d = br_cnt_q;
    mp_cnt_d = mp_cnt_q;
    if (resolve && decIsBranch && !(&br_cnt_q)) br_cnt_d = br_cnt_q + CNT_W'(1);
    if (mispred && !(&mp_cnt_q))                mp_cnt_d = mp_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      br_cnt_q <= '0;
      mp_cnt_q <= '0;
    end else begin
      br_cnt_q <= br_cnt_d;
      mp_cnt_q <= mp_cnt_d;
    end
  end

  assign branchCnt  = br_cnt_q;
  assign mispredCnt = mp_cnt_q;
endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor; a second narrow-counter instance shares
// all inputs so counter saturation is reachable in a short run.
module tb_branch_predictor;
  logic        clk = 1'b0;
  logic        rstN;
  logic [31:0] fetchPc, decTarget;
  logic        stall, decIsBranch, decEq;
  logic [31:0] nextPc, sm_nextPc;
  logic        predTaken, flush, sm_pred, sm_flush;
  logic [15:0] branchCnt, mispredCnt;
  logic [2:0]  sm_br, sm_mis;
  int nchk = 0;
  int nfail = 0;

  branch_predictor dut (
    .clk(clk), .rstN(rstN), .fetchPc(fetchPc), .stall(stall),
    .decIsBranch(decIsBranch), .decEq(decEq), .decTarget(decTarget),
    .nextPc(nextPc), .predTaken(predTaken), .flush(flush),
    .branchCnt(branchCnt), .mispredCnt(mispredCnt)
  );

  branch_predictor #(.CNT_W(3)) sm (
    .clk(clk), .rstN(rstN), .fetchPc(fetchPc), .stall(stall),
    .decIsBranch(decIsBranch), .decEq(decEq), .decTarget(decTarget),
    .nextPc(sm_nextPc), .predTaken(sm_pred), .flush(sm_flush),
    .branchCnt(sm_br), .mispredCnt(sm_mis)
  );

  always #5 clk = ~clk;

  task automatic drv(input logic [31:0] pc, input logic st, input logic br,
                     input logic eq, input logic [31:0] tgt);
    fetchPc = pc; stall = st; decIsBranch = br; decEq = eq; decTarget = tgt;
    #1;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rstN = 1'b0;
    drv(32'h100, 1'b0, 1'b0, 1'b0, 32'h0);
    repeat (2) @(posedge clk);
    #1 rstN = 1'b1;
  endtask

  task automatic test_reset();
    rstN = 1'b0;
    drv(32'h100, 1'b0, 1'b1, 1'b1, 32'h500);
    nchk++; if (flush !== 1'b0) begin nfail++; $display("FAIL rst_flush got %b want 0", flush); end
    nchk++; if (predTaken !== 1'b0) begin nfail++; $display("FAIL rst_pred got %b want 0", predTaken); end
    nchk++; if (nextPc !== 32'h104) begin nfail++; $display("FAIL rst_nextpc got %h want 104", nextPc); end
    nchk++; if (branchCnt !== 16'd0 || mispredCnt !== 16'd0) begin nfail++; $display("FAIL rst_cnt got %0d/%0d want 0/0", branchCnt, mispredCnt); end
    do_reset();
  endtask

  task automatic test_cold_miss();
    drv(32'h40, 1'b0, 1'b0, 1'b0, 32'h0);             // A
    nchk++; if (predTaken !== 1'b0 || nextPc !== 32'h44) begin nfail++; $display("FAIL cold_lookup got %b/%h want 0/44", predTaken, nextPc); end
    tick();
    drv(32'h44, 1'b0, 1'b1, 1'b1, 32'h20);            // B: taken, predicted not
    nchk++; if (flush !== 1'b1) begin nfail++; $display("FAIL cold_flush got %b want 1", flush); end
    nchk++; if (nextPc !== 32'h20) begin nfail++; $display("FAIL cold_redirect got %h want 20", nextPc); end
    tick();
    drv(32'h20, 1'b0, 1'b0, 1'b0, 32'h0);             // C: bubble in decode
    nchk++; if (flush !== 1'b0) begin nfail++; $display("FAIL cold_bubble got %b want 0", flush); end
    tick();
    drv(32'h40, 1'b0, 1'b0, 1'b0, 32'h0);             // D: entry now WT
    nchk++; if (predTaken !== 1'b1 || nextPc !== 32'h20) begin nfail++; $display("FAIL cold_trained got %b/%h want 1/20", predTaken, nextPc); end
    nchk++; if (branchCnt !== 16'd1 || mispredCnt !== 16'd1) begin nfail++; $display("FAIL cold_cnt got %0d/%0d want 1/1", branchCnt, mispredCnt); end
    tick();
  endtask

  task automatic test_loop_training();
    drv(32'h20, 1'b0, 1'b1, 1'b1, 32'h20);            // E: taken, correct -> ST
    nchk++; if (flush !== 1'b0 || nextPc !== 32'h24) begin nfail++; $display("FAIL loop_e got %b/%h want 0/24", flush, nextPc); end
    tick();
    drv(32'h40, 1'b0, 1'b0, 1'b0, 32'h0);             // F
    nchk++; if (predTaken !== 1'b1) begin nfail++; $display("FAIL loop_f got %b want 1", predTaken); end
    tick();
    drv(32'h20, 1'b0, 1'b1, 1'b1, 32'h20);            // G: stays ST
    tick();
    drv(32'h40, 1'b0, 1'b0, 1'b0, 32'h0);             // H
    tick();
    drv(32'h20, 1'b0, 1'b1, 1'b0, 32'h20);            // I: not taken -> WT
    nchk++; if (flush !== 1'b1 || nextPc !== 32'h44) begin nfail++; $display("FAIL loop_nt1 got %b/%h want 1/44", flush, nextPc); end
    tick();
    drv(32'h44, 1'b0, 1'b0, 1'b0, 32'h0);             // J
    tick();
    drv(32'h40, 1'b0, 1'b0, 1'b0, 32'h0);             // K: hysteresis
    nchk++; if (predTaken !== 1'b1 || nextPc !== 32'h20) begin nfail++; $display("FAIL loop_hyst got %b/%h want 1/20", predTaken, nextPc); end
    tick();
    drv(32'h20, 1'b0, 1'b1, 1'b0, 32'h20);            // L: not taken -> WNT
    nchk++; if (flush !== 1'b1 || nextPc !== 32'h44) begin nfail++; $display("FAIL loop_nt2 got %b/%h want 1/44", flush, nextPc); end
    tick();
    drv(32'h44, 1'b0, 1'b0, 1'b0, 32'h0);             // M
    tick();
    drv(32'h40, 1'b0, 1'b0, 1'b0, 32'h0);             // N
    nchk++; if (predTaken !== 1'b0 || nextPc !== 32'h44) begin nfail++; $display("FAIL loop_wnt got %b/%h want 0/44", predTaken, nextPc); end
    tick();
    drv(32'h44, 1'b0, 1'b1, 1'b0, 32'h20);            // O: correct not-taken
    nchk++; if (flush !== 1'b0 || nextPc !== 32'h48) begin nfail++; $display("FAIL loop_o got %b/%h want 0/48", flush, nextPc); end
    tick();
    nchk++; if (branchCnt !== 16'd6 || mispredCnt !== 16'd3) begin nfail++; $display("FAIL loop_cnt got %0d/%0d want 6/3", branchCnt, mispredCnt); end
  endtask

  task automatic test_alias();
    do_reset();
    drv(32'h40, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    drv(32'h44, 1'b0, 1'b1, 1'b1, 32'h20);            // allocate idx 0 as WT
    tick();
    drv(32'h440, 1'b0, 1'b0, 1'b0, 32'h0);            // same idx, other tag
    nchk++; if (predTaken !== 1'b0 || nextPc !== 32'h444) begin nfail++; $display("FAIL alias_miss got %b/%h want 0/444", predTaken, nextPc); end
    tick();
    drv(32'h40, 1'b0, 1'b0, 1'b0, 32'h0);
    nchk++; if (predTaken !== 1'b1 || flush !== 1'b0) begin nfail++; $display("FAIL alias_hit got %b/%b want 1/0", predTaken, flush); end
    tick();
    drv(32'h20, 1'b0, 1'b0, 1'b0, 32'h0);             // non-branch predicted taken
    nchk++; if (flush !== 1'b1 || nextPc !== 32'h44) begin nfail++; $display("FAIL alias_false got %b/%h want 1/44", flush, nextPc); end
    tick();
    drv(32'h40, 1'b0, 1'b0, 1'b0, 32'h0);
    nchk++; if (predTaken !== 1'b0 || nextPc !== 32'h44) begin nfail++; $display("FAIL alias_inval got %b/%h want 0/44", predTaken, nextPc); end
    nchk++; if (branchCnt !== 16'd1 || mispredCnt !== 16'd2) begin nfail++; $display("FAIL alias_cnt got %0d/%0d want 1/2", branchCnt, mispredCnt); end
    tick();
  endtask

  task automatic test_stall();
    do_reset();
    drv(32'h40, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    for (int i = 0; i < 2; i++) begin
      drv(32'h44, 1'b1, 1'b1, 1'b1, 32'h20);
      nchk++; if (flush !== 1'b0 || nextPc !== 32'h48) begin nfail++; $display("FAIL stall_hold%0d got %b/%h want 0/48", i, flush, nextPc); end
      tick();
      nchk++; if (branchCnt !== 16'd0) begin nfail++; $display("FAIL stall_cnt%0d got %0d want 0", i, branchCnt); end
    end
    drv(32'h44, 1'b0, 1'b1, 1'b1, 32'h20);
    nchk++; if (flush !== 1'b1 || nextPc !== 32'h20) begin nfail++; $display("FAIL stall_release got %b/%h want 1/20", flush, nextPc); end
    tick();
    drv(32'h20, 1'b0, 1'b1, 1'b1, 32'h20);
    nchk++; if (flush !== 1'b0) begin nfail++; $display("FAIL stall_once got %b want 0", flush); end
    tick();
    nchk++; if (branchCnt !== 16'd1 || mispredCnt !== 16'd1) begin nfail++; $display("FAIL stall_final got %0d/%0d want 1/1", branchCnt, mispredCnt); end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      drv(32'((i + 1) << 6), 1'b0, 1'b0, 1'b0, 32'h0);  // new tag each time -> miss
      tick();
      drv(32'h3000, 1'b0, 1'b1, 1'b1, 32'h3000);
      nchk++; if (flush !== 1'b1) begin nfail++; $display("FAIL sat_flush%0d got %b want 1", i, flush); end
      tick();
    end
    nchk++; if (mispredCnt !== 16'd10 || branchCnt !== 16'd10) begin nfail++; $display("FAIL sat_wide got %0d/%0d want 10/10", branchCnt, mispredCnt); end
    nchk++; if (sm_mis !== 3'd7 || sm_br !== 3'd7) begin nfail++; $display("FAIL sat_clamp got %0d/%0d want 7/7", sm_br, sm_mis); end
  endtask

  task automatic test_reset_midflight();
    drv(32'h280, 1'b0, 1'b0, 1'b0, 32'h0);
    nchk++; if (predTaken !== 1'b1 || nextPc !== 32'h3000) begin nfail++; $display("FAIL mid_pre got %b/%h want 1/3000", predTaken, nextPc); end
    tick();
    drv(32'h3000, 1'b0, 1'b1, 1'b0, 32'h3000);
    nchk++; if (flush !== 1'b1 || nextPc !== 32'h284) begin nfail++; $display("FAIL mid_flush got %b/%h want 1/284", flush, nextPc); end
    #1 rstN = 1'b0;
    #1;
    nchk++; if (flush !== 1'b0) begin nfail++; $display("FAIL mid_async got %b want 0", flush); end
    nchk++; if (branchCnt !== 16'd0 || mispredCnt !== 16'd0 || sm_mis !== 3'd0) begin nfail++; $display("FAIL mid_cnt got %0d/%0d/%0d want 0/0/0", branchCnt, mispredCnt, sm_mis); end
    drv(32'h280, 1'b0, 1'b0, 1'b0, 32'h0);
    nchk++; if (predTaken !== 1'b0 || nextPc !== 32'h284) begin nfail++; $display("FAIL mid_inrst got %b/%h want 0/284", predTaken, nextPc); end
    @(posedge clk); #1 rstN = 1'b1;
    drv(32'h280, 1'b0, 1'b0, 1'b0, 32'h0);
    nchk++; if (predTaken !== 1'b0) begin nfail++; $display("FAIL mid_after got %b want 0", predTaken); end
    tick();
    drv(32'h40, 1'b0, 1'b0, 1'b0, 32'h0);
    nchk++; if (predTaken !== 1'b0 || flush !== 1'b0) begin nfail++; $display("FAIL mid_after2 got %b/%b want 0/0", predTaken, flush); end
    tick();
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_loop_training();
    test_alias();
    test_stall();
    test_saturation();
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
